// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Single-cycle logic/arith ops, iterative one-bit-per-cycle shifts,
// and a registered result held until the consumer takes it.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] work, work_nxt, alu_res;
  logic [SHW-1:0]   cnt;
  logic [3:0]       sop;
  logic             smsb, alu_ill, is_shift, accept;

  // A held result frees the unit in the same cycle the consumer takes it.
  assign in_ready = rst_n & ((state == S_IDLE) | ((state == S_HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (alu_ctrl)
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_NOR: alu_res = ~(op_a | op_b);
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_res  = op_a;
        is_shift = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (sop)
      OP_SLL:  work_nxt = {work[WIDTH-2:0], 1'b0};
      OP_SRA:  work_nxt = {smsb, work[WIDTH-1:1]};
      default: work_nxt = {1'b0, work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
      work      <= '0;
      sop       <= OP_AND;
      smsb      <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state     <= S_HOLD;
            result    <= work_nxt;
            zero      <= (work_nxt == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            // Zero-amount shifts bypass the iterator and complete like any single-cycle op.
            if (is_shift && (op_b[SHW-1:0] != '0)) begin
              state     <= S_SHIFT;
              work      <= op_a;
              cnt       <= op_b[SHW-1:0];
              sop       <= alu_ctrl;
              smsb      <= op_a[WIDTH-1];
              out_valid <= 1'b0;
            end else begin
              state     <= S_HOLD;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              illegal   <= alu_ill;
              out_valid <= 1'b1;
            end
          end else if ((state == S_HOLD) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, result;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          due;
  } exp_t;
  exp_t q[$];

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what an op must produce, straight from the opcode table.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int n;
    n   = int'(b % 32);
    ill = 1'b0;
    lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b0011: begin r = a << n; lat = 1 + n; end
      4'b0100: begin r = a >> n; lat = 1 + n; end
      4'b0101: begin r = $unsigned($signed(a) >>> n); lat = 1 + n; end
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  // Per-cycle compare against the model; handshakes recorded for the coming edge.
  always @(negedge clk) begin
    logic ev, er, mill;
    logic [31:0] mr;
    int lat;
    exp_t e;
    cyc++;
    ev = (q.size() > 0) && (cyc >= q[0].due);
    er = rst_n && ((q.size() == 0) || (ev && out_ready));
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, er});
    if (ev) begin
      chk("m_result", result, q[0].res);
      chk("m_zero", {31'd0, zero}, {31'd0, q[0].res == 32'd0});
      chk("m_illegal", {31'd0, illegal}, {31'd0, q[0].ill});
    end
    if (!rst_n) q.delete();
    else begin
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && er) begin
        model(alu_ctrl, op_a, op_b, mr, mill, lat);
        e.res = mr; e.ill = mill; e.due = cyc + lat;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin errs++; $display("FAIL send_timeout: ctrl %b never accepted", c); end
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; alu_ctrl = 4'b0010;
  endtask

  task automatic wait_out(input string name, input logic [31:0] er, input logic ez,
                          input logic ei, input int elat);
    bit ok = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        chk({name, "_result"}, result, er);
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
        chk({name, "_illegal"}, {31'd0, illegal}, {31'd0, ei});
        chk({name, "_latency"}, i, elat);
        break;
      end
    end
    if (!ok) begin errs++; $display("FAIL %s_timeout: out_valid never rose", name); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = 4'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    send(4'b0010, 32'h7FFF_FFFF, 32'd1);     wait_out("add", 32'h8000_0000, 0, 0, 1);
    send(4'b0110, 32'h1234, 32'h1234);       wait_out("sub_eq", 32'd0, 1, 0, 1);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1);     wait_out("slt_neg", 32'd1, 0, 0, 1);
    send(4'b0111, 32'd1, 32'hFFFF_FFFF);     wait_out("slt_pos", 32'd0, 1, 0, 1);
    send(4'b0101, 32'h8000_0000, 32'd4);     wait_out("sra4", 32'hF800_0000, 0, 0, 5);
    send(4'b0011, 32'hA5A5_0F0F, 32'h20);    wait_out("sll0", 32'hA5A5_0F0F, 0, 0, 1);
    send(4'b0100, 32'hF000_0000, 32'hFFE3);  wait_out("srl3", 32'h1E00_0000, 0, 0, 4);
    send(4'b0011, 32'd1, 32'd31);            wait_out("sll31", 32'h8000_0000, 0, 0, 32);
    send(4'b1100, 32'd0, 32'd0);             wait_out("nor", 32'hFFFF_FFFF, 0, 0, 1);
    send(4'b1111, 32'h1234, 32'h5678);       wait_out("ill_f", 32'd0, 1, 1, 1);
    send(4'b1000, 32'hFFFF, 32'hFFFF);       wait_out("ill_8", 32'd0, 1, 1, 1);

    // Backpressure, then consume-and-accept in one cycle.
    @(posedge clk); #1 out_ready = 1'b0;
    send(4'b0001, 32'hF0, 32'h0F);           wait_out("or", 32'hFF, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_result", result, 32'hFF);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0000; op_a = 32'hFF00; op_b = 32'h0FF0;
    @(negedge clk);
    chk("swap_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("and_out_valid", {31'd0, out_valid}, 32'd1);
    chk("and_result", result, 32'h0F00);

    // Streaming: one ADD accepted per cycle.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'(k * 16); op_b = 32'd3;
      @(negedge clk);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", result, 32'd51);

    // Reset in the second shift cycle of SRL by 10.
    @(posedge clk); #1;
    send(4'b0100, 32'hFFFF_0000, 32'd10);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    send(4'b0010, 32'd2, 32'd3);             wait_out("after_rst", 32'd5, 0, 0, 1);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit alu_ctrl code from the ALU control decoder plus two operands, and produces a registered result and zero flag.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) complete in one clock.
- Shifts run iteratively, one bit per cycle, behind a valid/ready handshake on input and output.
- Sits between operand select (rs1, rs2/imm mux) and the writeback/branch-compare logic.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2, >= 8.
- SHW, 5, shift-amount width = log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  operands and alu_ctrl valid.
- in_ready  out  1  unit can accept this cycle.
- alu_ctrl  in  4  operation code.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B; for shifts, op_b[SHW-1:0] is the shift amount and upper bits are ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- illegal  out  1  alu_ctrl was not a defined code.

Behaviour:
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH); 0110 SUB (a-b, mod 2^WIDTH).
  - 0111 SLT (signed a<b -> 1, else 0).
  - 1100 NOR.
  - 0011 SLL; 0100 SRL; 0101 SRA (sign-fill).
  - Any other code -> result 0, illegal=1, single-cycle.
- Accept condition: in_valid & in_ready. Operands and code are captured on accept; later input changes have no effect on the op in flight.
- State machine:
  - IDLE:
    - in_ready=1, out_valid=0.
    - Accept of a non-shift op -> HOLD next cycle with result loaded.
    - Accept of a shift with amount 0 -> HOLD, result=op_a.
    - Accept of a shift with amount n>0 -> SHIFT, working reg=op_a, counter=n.
  - SHIFT:
    - in_ready=0, out_valid=0.
    - Each cycle: shift working reg by 1 in the selected direction; SRA replicates the captured MSB; counter decrements.
    - When counter reaches 0, the final value is loaded into result and the FSM enters HOLD.
    - Total latency from accept to out_valid = 1+n cycles.
  - HOLD:
    - out_valid=1; result, zero and illegal are stable.
    - out_ready=0 -> stay, outputs unchanged.
    - out_ready=1 -> in_ready=1 this cycle (combinational from out_ready).
    - If in_valid is also 1, the new op is accepted and the next state follows the IDLE rules. Back-to-back single-cycle ops therefore sustain one per cycle.
    - Otherwise -> IDLE.
- zero and illegal are registered together with result and valid only while out_valid=1. In IDLE and SHIFT they hold their last values and must be ignored.
- Reset (rst_n=0 at a clock edge, in any state, including mid-shift):
  - state=IDLE, result=0, zero=0, illegal=0, out_valid=0, counter=0.
  - in_ready is 1 from the first cycle after reset release.
  - An in-flight op is discarded; nothing is output for it.
- in_ready is 0 throughout reset.
- No combinational path from in_valid/op_a/op_b/alu_ctrl to any output. The only combinational path is out_ready -> in_ready.

Test Plan:
- Reset then ADD: a=0x7FFFFFFF, b=1, ctrl=0010 -> next cycle out_valid=1, result=0x80000000, zero=0, illegal=0.
- SUB equal: a=b=0x1234, ctrl=0110 -> result=0, zero=1 after 1 cycle.
- SLT: a=0xFFFFFFFF, b=1 -> 1. Then a=1, b=0xFFFFFFFF -> 0.
- Shifts:
  - SRA a=0x80000000, b=4 -> out_valid exactly 5 cycles after accept, result=0xF8000000, in_ready=0 during the 4 SHIFT cycles.
  - SLL with b=0x20 (amount 0) -> result=a after 1 cycle.
- Backpressure and streaming:
  - Hold out_ready=0 for 3 cycles after an OR result -> result stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 AND -> OR result consumed and AND accepted in the same cycle; AND result valid next cycle.
- Illegal code 1111 -> illegal=1, result=0. Assert rst_n=0 on the 2nd cycle of a SRL by 10 -> out_valid=0, result=0 the next cycle, and no stale result appears afterwards.
